bus_slot_master: RTL and testbench



---
 rtl/bus_slot_master.sv | 162 ++++++++++++++++
 tb/tb_bus_slot_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slot_master.sv
`timescale 1ns/1ps
// Bus slot master: queues one RAM read/write and runs it in the next full
// 2-cycle SPI ownership slot, driving registered address, data and strobes.
module bus_slot_master #(
  parameter int unsigned AW = 17,
  parameter int unsigned DW = 8
) (
  input  logic          clk_16_i,
  input  logic          rst_ni,
  input  logic          spi_enable_i,
  input  logic          req_i,
  input  logic          rw_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          ready_o,
  output logic          done_o,
  output logic [DW-1:0] rd_data_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_data_o,
  output logic          bus_data_oe_o,
  input  logic [DW-1:0] bus_data_i,
  output logic          ram_oe_no,
  output logic          ram_we_no
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    ACCESS0   = 2'd2,
    ACCESS1   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state;
  logic            r_spi_en_q;
  logic            r_rw;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_ready;
  logic            r_done;
  logic            r_oe_n;
  logic            r_we_n;
  logic            r_data_oe;
  logic [AW-1:0]   r_bus_addr;
  logic [DW-1:0]   r_bus_data;
  logic [DW-1:0]   r_rd_data;

  logic            w_slot_start;
  logic            w_strobe;
  logic            w_rw;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic            w_done;
  logic            w_oe_n;
  logic            w_we_n;
  logic            w_data_oe;
  logic [AW-1:0]   w_bus_addr;
  logic [DW-1:0]   w_bus_data;
  logic [DW-1:0]   w_rd_data;

  // Only a fresh rising slot counts; a slot already under way is skipped.
  assign w_slot_start = spi_enable_i & ~r_spi_en_q;

  // Next-state and next-output logic
  always_comb begin
    w_state    = r_state;
    w_rw       = r_rw;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_done     = 1'b0;
    w_strobe   = 1'b0;
    w_oe_n     = 1'b1;
    w_we_n     = 1'b1;
    w_data_oe  = 1'b0;
    w_bus_addr = r_bus_addr;
    w_bus_data = r_bus_data;
    w_rd_data  = r_rd_data;

    case (r_state)
      IDLE: begin
        if (req_i) begin
          w_rw    = rw_i;
          w_addr  = addr_i;
          w_wdata = wr_data_i;
          w_state = WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        if (w_slot_start) begin
          w_state  = ACCESS0;
          w_strobe = 1'b1;
        end
      end
      ACCESS0: begin
        w_state  = ACCESS1;
        w_strobe = 1'b1;
      end
      ACCESS1: begin
        w_state = IDLE;
        w_done  = 1'b1;
        if (r_rw) begin
          w_rd_data = bus_data_i;
        end
      end
      default: w_state = IDLE;
    endcase

    if (w_strobe) begin
      w_bus_addr = r_addr;
      if (r_rw) begin
        w_oe_n = 1'b0;
      end else begin
        w_we_n     = 1'b0;
        w_data_oe  = 1'b1;
        w_bus_data = r_wdata;
      end
    end
  end

  // State and registered outputs; reset drops strobes without a clock.
  always_ff @(posedge clk_16_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_spi_en_q <= 1'b1;
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_data_oe  <= 1'b0;
      r_bus_addr <= '0;
      r_bus_data <= '0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_state;
      r_spi_en_q <= spi_enable_i;
      r_rw       <= w_rw;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_ready    <= (w_state == IDLE);
      r_done     <= w_done;
      r_oe_n     <= w_oe_n;
      r_we_n     <= w_we_n;
      r_data_oe  <= w_data_oe;
      r_bus_addr <= w_bus_addr;
      r_bus_data <= w_bus_data;
      r_rd_data  <= w_rd_data;
    end
  end

  assign ready_o       = r_ready;
  assign done_o        = r_done;
  assign rd_data_o     = r_rd_data;
  assign bus_addr_o    = r_bus_addr;
  assign bus_data_o    = r_bus_data;
  assign bus_data_oe_o = r_data_oe;
  assign ram_oe_no     = r_oe_n;
  assign ram_we_no     = r_we_n;

endmodule

// File: tb/tb_bus_slot_master.sv
`timescale 1ns/1ps
// Directed bench for bus_slot_master: a free-running 16-phase slot generator
// and per-scenario tasks with hand-computed strobe and done timing.
module tb_bus_slot_master;

  logic        clk_16_i     = 1'b0;
  logic        rst_ni       = 1'b0;
  logic        spi_enable_i;
  logic        req_i        = 1'b0;
  logic        rw_i         = 1'b0;
  logic [16:0] addr_i       = '0;
  logic [7:0]  wr_data_i    = '0;
  logic [7:0]  bus_data_i   = '0;
  logic        ready_o;
  logic        done_o;
  logic [7:0]  rd_data_o;
  logic [16:0] bus_addr_o;
  logic [7:0]  bus_data_o;
  logic        bus_data_oe_o;
  logic        ram_oe_no;
  logic        ram_we_no;

  logic [3:0]  phase = 4'd4;
  int          n_vec = 0;
  int          n_err = 0;

  // Observation results filled by observe()
  int          obs_we, obs_oe, obs_doe, obs_overlap, obs_first, obs_done_tick, obs_done_cnt;
  logic [16:0] obs_addr;
  logic [7:0]  obs_data;
  logic [7:0]  obs_rd;

  bus_slot_master dut (
    .clk_16_i      (clk_16_i),
    .rst_ni        (rst_ni),
    .spi_enable_i  (spi_enable_i),
    .req_i         (req_i),
    .rw_i          (rw_i),
    .addr_i        (addr_i),
    .wr_data_i     (wr_data_i),
    .ready_o       (ready_o),
    .done_o        (done_o),
    .rd_data_o     (rd_data_o),
    .bus_addr_o    (bus_addr_o),
    .bus_data_o    (bus_data_o),
    .bus_data_oe_o (bus_data_oe_o),
    .bus_data_i    (bus_data_i),
    .ram_oe_no     (ram_oe_no),
    .ram_we_no     (ram_we_no)
  );

  always #31 clk_16_i = ~clk_16_i;

  // Slot generator: enable high for phases 0 and 1, changes on falling edge
  always @(negedge clk_16_i) phase <= phase + 4'd1;
  assign spi_enable_i = (phase < 4'd2);

  task automatic tick();
    @(negedge clk_16_i);
    #1;
  endtask

  task automatic wait_phase(input logic [3:0] p);
    int k;
    k = 0;
    while (phase !== p && k < 40) begin
      tick();
      k++;
    end
  endtask

  // Sample j is taken after edge acceptance+j; req_i drops after acceptance
  task automatic observe(input int n);
    obs_we = 0; obs_oe = 0; obs_doe = 0; obs_overlap = 0;
    obs_first = -1; obs_done_tick = -1; obs_done_cnt = 0;
    obs_addr = '0; obs_data = '0; obs_rd = '0;
    for (int j = 0; j < n; j++) begin
      tick();
      if (j == 0) req_i = 1'b0;
      if (ram_we_no === 1'b0) obs_we++;
      if (ram_oe_no === 1'b0) obs_oe++;
      if (bus_data_oe_o === 1'b1) obs_doe++;
      if (ram_we_no === 1'b0 && ram_oe_no === 1'b0) obs_overlap++;
      if ((ram_we_no === 1'b0 || ram_oe_no === 1'b0) && obs_first < 0) begin
        obs_first = j;
        obs_addr  = bus_addr_o;
        obs_data  = bus_data_o;
      end
      if (done_o === 1'b1) begin
        obs_done_cnt++;
        if (obs_done_tick < 0) begin
          obs_done_tick = j;
          obs_rd        = rd_data_o;
        end
      end
    end
  endtask

  task automatic test_reset();
    n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", ready_o); end
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done_o); end
    n_vec++; if (ram_oe_no !== 1'b1) begin n_err++; $display("FAIL rst_oe_n: got %b want 1", ram_oe_no); end
    n_vec++; if (ram_we_no !== 1'b1) begin n_err++; $display("FAIL rst_we_n: got %b want 1", ram_we_no); end
    n_vec++; if (bus_data_oe_o !== 1'b0) begin n_err++; $display("FAIL rst_data_oe: got %b want 0", bus_data_oe_o); end
    n_vec++; if (bus_addr_o !== 17'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", bus_addr_o); end
    n_vec++; if (bus_data_o !== 8'h0) begin n_err++; $display("FAIL rst_bus_data: got %h want 0", bus_data_o); end
    n_vec++; if (rd_data_o !== 8'h0) begin n_err++; $display("FAIL rst_rd_data: got %h want 0", rd_data_o); end
  endtask

  task automatic test_write();
    wait_phase(4'd15);
    rw_i = 1'b0; addr_i = 17'h12345; wr_data_i = 8'hA5; req_i = 1'b1;
    observe(8);
    n_vec++; if (obs_we !== 2) begin n_err++; $display("FAIL wr_we_cycles: got %0d want 2", obs_we); end
    n_vec++; if (obs_doe !== 2) begin n_err++; $display("FAIL wr_oe_drive_cycles: got %0d want 2", obs_doe); end
    n_vec++; if (obs_oe !== 0) begin n_err++; $display("FAIL wr_no_read_strobe: got %0d want 0", obs_oe); end
    n_vec++; if (obs_first !== 1) begin n_err++; $display("FAIL wr_strobe_start: got %0d want 1", obs_first); end
    n_vec++; if (obs_addr !== 17'h12345) begin n_err++; $display("FAIL wr_bus_addr: got %h want 12345", obs_addr); end
    n_vec++; if (obs_data !== 8'hA5) begin n_err++; $display("FAIL wr_bus_data: got %h want a5", obs_data); end
    n_vec++; if (obs_done_tick !== 3) begin n_err++; $display("FAIL wr_done_latency: got %0d want 3", obs_done_tick); end
    n_vec++; if (obs_done_cnt !== 1) begin n_err++; $display("FAIL wr_done_width: got %0d want 1", obs_done_cnt); end
    n_vec++; if (bus_addr_o !== 17'h12345) begin n_err++; $display("FAIL wr_addr_hold: got %h want 12345", bus_addr_o); end
    n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL wr_ready_after: got %b want 1", ready_o); end
  endtask

  task automatic test_read();
    wait_phase(4'd15);
    rw_i = 1'b1; addr_i = 17'h08000; bus_data_i = 8'h3C; req_i = 1'b1;
    observe(8);
    n_vec++; if (obs_oe !== 2) begin n_err++; $display("FAIL rd_oe_cycles: got %0d want 2", obs_oe); end
    n_vec++; if (obs_we !== 0) begin n_err++; $display("FAIL rd_no_write_strobe: got %0d want 0", obs_we); end
    n_vec++; if (obs_doe !== 0) begin n_err++; $display("FAIL rd_no_drive: got %0d want 0", obs_doe); end
    n_vec++; if (obs_addr !== 17'h08000) begin n_err++; $display("FAIL rd_bus_addr: got %h want 08000", obs_addr); end
    n_vec++; if (obs_done_tick !== 3) begin n_err++; $display("FAIL rd_done_latency: got %0d want 3", obs_done_tick); end
    n_vec++; if (obs_rd !== 8'h3C) begin n_err++; $display("FAIL rd_data_at_done: got %h want 3c", obs_rd); end
    n_vec++; if (bus_data_o !== 8'hA5) begin n_err++; $display("FAIL rd_bus_data_hold: got %h want a5", bus_data_o); end
  endtask

  task automatic test_late_slot();
    wait_phase(4'd1);
    rw_i = 1'b0; addr_i = 17'h1FFFF; wr_data_i = 8'h5A; bus_data_i = 8'h99; req_i = 1'b1;
    observe(22);
    n_vec++; if (obs_first !== 15) begin n_err++; $display("FAIL late_strobe_start: got %0d want 15", obs_first); end
    n_vec++; if (obs_we !== 2) begin n_err++; $display("FAIL late_we_cycles: got %0d want 2", obs_we); end
    n_vec++; if (obs_done_tick !== 17) begin n_err++; $display("FAIL late_done_latency: got %0d want 17", obs_done_tick); end
    n_vec++; if (obs_data !== 8'h5A) begin n_err++; $display("FAIL late_bus_data: got %h want 5a", obs_data); end
    n_vec++; if (rd_data_o !== 8'h3C) begin n_err++; $display("FAIL late_rd_kept: got %h want 3c", rd_data_o); end
  endtask

  task automatic test_worst_case();
    wait_phase(4'd0);
    rw_i = 1'b1; addr_i = 17'h00001; bus_data_i = 8'hC3; req_i = 1'b1;
    observe(22);
    n_vec++; if (obs_first !== 16) begin n_err++; $display("FAIL worst_strobe_start: got %0d want 16", obs_first); end
    n_vec++; if (obs_done_tick !== 18) begin n_err++; $display("FAIL worst_done_latency: got %0d want 18", obs_done_tick); end
    n_vec++; if (obs_rd !== 8'hC3) begin n_err++; $display("FAIL worst_rd_data: got %h want c3", obs_rd); end
  endtask

  task automatic test_back_to_back();
    int s1, s2, d1, d2, overlap, oe_cnt;
    logic [16:0] a1, a2;
    logic [7:0]  r1, r2;
    logic        rdy3, rdy4, prev_oe_n;
    s1 = -1; s2 = -1; d1 = -1; d2 = -1; overlap = 0; oe_cnt = 0;
    a1 = '0; a2 = '0; r1 = '0; r2 = '0; rdy3 = 1'b0; rdy4 = 1'b1; prev_oe_n = 1'b1;
    wait_phase(4'd15);
    rw_i = 1'b1; addr_i = 17'h00AAA; bus_data_i = 8'h11; req_i = 1'b1;
    for (int j = 0; j < 24; j++) begin
      tick();
      if (j == 0) addr_i = 17'h00BBB;
      if (j == 5) req_i = 1'b0;
      if (j == 3) rdy3 = ready_o;
      if (j == 4) rdy4 = ready_o;
      if (ram_oe_no === 1'b0) oe_cnt++;
      if (ram_oe_no === 1'b0 && ram_we_no === 1'b0) overlap++;
      if (ram_oe_no === 1'b0 && prev_oe_n === 1'b1) begin
        if (s1 < 0) begin s1 = j; a1 = bus_addr_o; end
        else if (s2 < 0) begin s2 = j; a2 = bus_addr_o; end
      end
      prev_oe_n = ram_oe_no;
      if (done_o === 1'b1) begin
        if (d1 < 0) begin d1 = j; r1 = rd_data_o; bus_data_i = 8'h22; end
        else if (d2 < 0) begin d2 = j; r2 = rd_data_o; end
      end
    end
    n_vec++; if (s1 !== 1 || d1 !== 3) begin n_err++; $display("FAIL b2b_first_timing: got strobe %0d done %0d want 1 3", s1, d1); end
    n_vec++; if (s2 !== 17 || d2 !== 19) begin n_err++; $display("FAIL b2b_second_timing: got strobe %0d done %0d want 17 19", s2, d2); end
    n_vec++; if (rdy3 !== 1'b1 || rdy4 !== 1'b0) begin n_err++; $display("FAIL b2b_reaccept: got ready %b %b want 1 0", rdy3, rdy4); end
    n_vec++; if (a1 !== 17'h00AAA || a2 !== 17'h00BBB) begin n_err++; $display("FAIL b2b_addr: got %h %h want 00aaa 00bbb", a1, a2); end
    n_vec++; if (r1 !== 8'h11 || r2 !== 8'h22) begin n_err++; $display("FAIL b2b_rd_data: got %h %h want 11 22", r1, r2); end
    n_vec++; if (oe_cnt !== 4 || overlap !== 0) begin n_err++; $display("FAIL b2b_strobes: got oe %0d overlap %0d want 4 0", oe_cnt, overlap); end
  endtask

  task automatic test_reset_abort();
    wait_phase(4'd15);
    rw_i = 1'b0; addr_i = 17'h0F0F0; wr_data_i = 8'hFF; req_i = 1'b1;
    tick();
    req_i = 1'b0;
    tick();
    n_vec++; if (ram_we_no !== 1'b0) begin n_err++; $display("FAIL abort_pre_we: got %b want 0", ram_we_no); end
    rst_ni = 1'b0;
    #2;
    n_vec++; if (ram_we_no !== 1'b1) begin n_err++; $display("FAIL abort_we_n: got %b want 1", ram_we_no); end
    n_vec++; if (bus_data_oe_o !== 1'b0) begin n_err++; $display("FAIL abort_data_oe: got %b want 0", bus_data_oe_o); end
    n_vec++; if (bus_addr_o !== 17'h0 || rd_data_o !== 8'h0) begin n_err++; $display("FAIL abort_regs: got addr %h rd %h want 0 0", bus_addr_o, rd_data_o); end
    tick();
    rst_ni = 1'b1;
    observe(20);
    n_vec++; if (obs_done_cnt !== 0 || obs_we !== 0) begin n_err++; $display("FAIL abort_no_done: got done %0d we %0d want 0 0", obs_done_cnt, obs_we); end
    n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_release_in_slot();
    wait_phase(4'd15);
    rst_ni = 1'b0;
    tick();
    rw_i = 1'b1; addr_i = 17'h10001; bus_data_i = 8'h77; req_i = 1'b1;
    rst_ni = 1'b1;
    observe(22);
    n_vec++; if (obs_first !== 16) begin n_err++; $display("FAIL rel_strobe_start: got %0d want 16", obs_first); end
    n_vec++; if (obs_done_tick !== 18) begin n_err++; $display("FAIL rel_done_latency: got %0d want 18", obs_done_tick); end
    n_vec++; if (obs_rd !== 8'h77 || obs_addr !== 17'h10001) begin n_err++; $display("FAIL rel_access: got rd %h addr %h want 77 10001", obs_rd, obs_addr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    repeat (3) tick();
    test_reset();
    rst_ni = 1'b1;
    tick();
    test_write();
    test_read();
    test_late_slot();
    test_worst_case();
    test_back_to_back();
    test_reset_abort();
    test_release_in_slot();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
